// File: rtl/psram_responder.sv
// rtl/psram_responder.sv - cellular PSRAM pin-level responder with programmable access latency
//
// Stands in for one PSRAM die. The controller-side pins are sampled on clk. An
// ADV# strobe latches a word address, then cram_wait is held high for LAT
// cycles, and then one word is read from or written to the internal array
// (or the BCR when CRE was set at address time).
//
// Optional feature macro: PSRAM_RESP_CRE_EN
//   defined   : Bus Configuration Register implemented (cre=1 accesses hit it)
//   undefined : cre=1 writes are dropped, cre=1 reads return 16'h0000
//
// Ports:
//   clk, reset_n              sampling clock, asynchronous active-low reset
//   cram_a[5:0]               address bits [21:16]
//   cram_dq_in[15:0]          DQ from the pins (A[15:0] while adv_n=0)
//   cram_dq_out[15:0]         read data
//   cram_dq_oe                DQ output enable for the top-level tristate
//   cram_adv_n, cram_cre      address valid, configuration register enable
//   cram_ce_n, cram_oe_n      chip enable, output enable
//   cram_we_n                 write enable
//   cram_ub_n, cram_lb_n      upper/lower byte lane enables
//   cram_wait                 high while access latency is in progress
module psram_responder #(
  parameter int          ADDR_W    = 12,
  parameter int          LAT       = 3,
  parameter logic [15:0] BCR_RESET = 16'h9D1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  cram_a,
  input  logic [15:0] cram_dq_in,
  output logic [15:0] cram_dq_out,
  output logic        cram_dq_oe,
  input  logic        cram_adv_n,
  input  logic        cram_cre,
  input  logic        cram_ce_n,
  input  logic        cram_oe_n,
  input  logic        cram_we_n,
  input  logic        cram_ub_n,
  input  logic        cram_lb_n,
  output logic        cram_wait
);

  typedef enum logic [1:0] {IDLE, LATENCY, READ, WRITE} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [ADDR_W-1:0] addr;
  logic              cre_q;
  logic [15:0]       dq_q;
  logic [15:0]       bcr_val;
  logic [15:0]       rd_word;
  logic              latch;
  logic              wr_en;

  logic [15:0] mem [2**ADDR_W];

  assign latch = !cram_ce_n && !cram_adv_n;
  // A re-latch edge belongs to the new access, so it never commits the old write.
  assign wr_en = (state == WRITE) && !cram_ce_n && !cram_we_n && cram_adv_n;

  assign rd_word = cre_q ? bcr_val : mem[addr];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (cram_ce_n) begin
      state_next = IDLE;
    end else if (!cram_adv_n) begin
      state_next = LATENCY;
      cnt_next   = 4'(LAT - 1);
    end else begin
      case (state)
        LATENCY: begin
          if (cnt == 4'd0) state_next = cram_we_n ? READ : WRITE;
          else             cnt_next   = cnt - 4'd1;
        end
        READ:    if (!cram_we_n) state_next = WRITE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      cre_q <= 1'b0;
      dq_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch) begin
        addr  <= ADDR_W'({cram_a, cram_dq_in});
        cre_q <= cram_cre;
      end
      // Fetch while waiting so the word is already on dq_out when READ begins.
      if (state == LATENCY || state == READ) dq_q <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !cre_q) begin
      if (!cram_ub_n) mem[addr][15:8] <= cram_dq_in[15:8];
      if (!cram_lb_n) mem[addr][7:0]  <= cram_dq_in[7:0];
    end
  end

`ifdef PSRAM_RESP_CRE_EN
  logic [15:0] bcr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          bcr <= BCR_RESET;
    else if (wr_en && cre_q) bcr <= cram_dq_in;
  end

  assign bcr_val = bcr;
`else
  logic unused_bcr_reset;

  assign unused_bcr_reset = ^BCR_RESET;
  assign bcr_val          = 16'h0000;
`endif

  assign cram_wait   = (state == LATENCY);
  assign cram_dq_oe  = (state == READ) && !cram_oe_n && !cram_ce_n && cram_we_n;
  assign cram_dq_out = dq_q;

endmodule

// File: doc/psram_responder.md
# psram_responder

Clocked, synthesizable responder for the cellular PSRAM pin interface (cram0/cram1 style: multiplexed address/data, ADV#, CRE, WAIT, byte lanes). It samples the controller-side pins on `clk`, latches a 22-bit word address, and inserts a programmable access latency signalled on `cram_wait`. It then serves word reads or byte-masked writes from an internal array, or from the Bus Configuration Register (BCR). It stands in for one PSRAM die in simulation and FPGA loopback benches, so the `psram` controller and the `rv32i_top` MA stage can be exercised without the physical chip.

## Interface
Parameters:
- `ADDR_W`, 12: implemented word-address bits; array depth is 2**ADDR_W x 16.
- `LAT`, 3: access latency in `clk` cycles, legal range 1..15.
- `BCR_RESET`, 16'h9D1F: reset value of the BCR.

Ports (clk, reset_n asynchronous active-low):
- `clk` in 1: sampling clock.
- `reset_n` in 1: async active-low reset.
- `cram_a` in 6: address bits [21:16].
- `cram_dq_in` in 16: DQ as seen from the pins; carries A[15:0] while `cram_adv_n`=0.
- `cram_dq_out` out 16: read data.
- `cram_dq_oe` out 1: DQ output enable; the top level builds the tristate.
- `cram_adv_n` in 1: address valid, active-low.
- `cram_cre` in 1: configuration register enable.
- `cram_ce_n` in 1: chip enable, active-low.
- `cram_oe_n` in 1: output enable, active-low.
- `cram_we_n` in 1: write enable, active-low.
- `cram_ub_n` in 1: upper byte lane enable, active-low.
- `cram_lb_n` in 1: lower byte lane enable, active-low.
- `cram_wait` out 1: high while latency is in progress.

## Operation
- Reset values: state IDLE, `cram_wait`=0, `cram_dq_oe`=0, `cram_dq_out`=0, BCR=`BCR_RESET`, latched addr=0, latched cre=0. Array contents are not reset.
- States: IDLE, LATENCY, READ, WRITE.
- Address latch:
  - In any state, a posedge with `ce_n`=0 and `adv_n`=0 latches `addr` = {cram_a, cram_dq_in}[ADDR_W-1:0], where high bits beyond ADDR_W are dropped, so addresses wrap.
  - The same posedge latches `cre`, loads the counter with LAT-1, and moves to LATENCY.
  - A re-latch mid-transaction aborts the current access; no write from the aborted access is committed afterwards.
- LATENCY:
  - The counter decrements each cycle.
  - At 0: if `we_n`=0, go to WRITE; otherwise go to READ.
  - The read word (array or BCR) is fetched during LATENCY, so `cram_dq_out` is valid on entry to READ.
- READ:
  - `cram_dq_out` holds mem[addr], or the BCR when cre=1.
  - `cram_dq_oe` = (state==READ) && !`oe_n` && !`ce_n`, combinational.
  - If `we_n` falls while in READ, go to WRITE.
- WRITE:
  - Every cycle with `ce_n`=0 and `we_n`=0, write `cram_dq_in`[15:8] if `ub_n`=0 and `cram_dq_in`[7:0] if `lb_n`=0.
  - Repeated cycles rewrite the same data, which is idempotent.
  - If cre=1, the write targets the BCR (byte lanes ignored, full word written) instead of the array.
- `oe_n`=0 and `we_n`=0 together: the write takes effect and `cram_dq_oe`=0.
- `ce_n`=1 sampled in any state: return to IDLE next cycle, `cram_wait`=0. `cram_dq_oe` drops combinationally.
- No address auto-increment: single-word accesses only, no bursts.

## Timing
- Latch at posedge T: `cram_wait`=1 for cycles T+1..T+LAT, then 0 from T+LAT+1, which is also the first READ/WRITE cycle.
- Read data is valid on `cram_dq_out` from T+LAT+1; `cram_dq_oe` follows `oe_n` in the same cycle.
- Write data is committed at each posedge in WRITE where the write condition holds; a read of the same address in a later transaction returns it.
- `reset_n` asserted mid-access: all outputs take reset values immediately (asynchronous).

## Configuration
- `PSRAM_RESP_CRE_EN` defined: BCR implemented. cre=1 writes load the BCR and cre=1 reads return it.
- Not defined: no BCR storage. cre=1 writes are dropped (array untouched); cre=1 reads return 16'h0000 with normal latency and handshake.

## Test plan
- Write then read: write 16'hBEEF to addr 0x000123 (ub_n=lb_n=0), then read 0x000123 -> `cram_wait` high exactly 3 cycles, `cram_dq_out`=16'hBEEF with `cram_dq_oe`=1 while oe_n=0.
- Byte lanes: mem[0x10]=16'h1234; write 16'hABCD with ub_n=1, lb_n=0 -> a read returns 16'h12CD.
- Address wrap (ADDR_W=12): write 16'h5555 to 0x001005, then read 0x000005 -> 16'h5555.
- CRE, macro defined: read with cre=1 after reset -> 16'h9D1F; write 16'h8000 with cre=1 then read with cre=1 -> 16'h8000, and array addr 0 unchanged. Macro undefined: the same read returns 16'h0000.
- Abort: `ce_n` goes high during LATENCY -> `cram_wait`=0 next cycle, no data driven. A re-latch during WRITE -> the old address is not written after the re-latch.
- Reset mid-READ: assert reset_n=0 -> `cram_dq_oe`, `cram_wait`, `cram_dq_out` = 0 immediately; BCR = 16'h9D1F.
